ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit: the initiator side of the instruction-memory interface. It drives a 16-bit word address into the combinational instruction memory, captures the returned 16-bit command together with its PC into a small prefetch buffer, and presents {pc, com} to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and accepts PC redirects (branch/jump resolved downstream) and a halt request.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `DEPTH`, default 2: prefetch buffer entries, a power of two, at least 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  16: instruction memory address, equal to the current PC register.
- `imem_com`  in  16: instruction word for `imem_addr`, valid in the same cycle.
- `out_valid`  out  1: buffer head holds an instruction.
- `out_ready`  in  1: decode accepts the head this cycle.
- `out_com`  out  16: head instruction word.
- `out_pc`  out  16: address of the head instruction.
- `redir_valid`  in  1: one-cycle request to flush and restart fetch.
- `redir_pc`  in  16: restart address, sampled when `redir_valid` is 1.
- `halt`  in  1: level signal; while 1, no new fetches are made.
- `fetch_cnt`  out  16: count of words written into the buffer; wraps.

## Operation
- Fetch condition: `push = !redir_valid && !halt && (count < DEPTH || pop)`.
- Pop condition: `pop = out_valid && out_ready`.
- On push: write {pc, imem_com} at the buffer tail, set pc <= pc + 1 (mod 2^16, so 16'hFFFF wraps to 0), and set fetch_cnt <= fetch_cnt + 1.
- Redirect has the highest priority:
  - pc <= redir_pc.
  - The buffer is emptied.
  - No push occurs.
  - `out_valid` is forced to 0 combinationally in that cycle, so no handshake can complete.
- Halt: pc is frozen and the buffer keeps draining normally. A redirect during halt still loads pc and flushes the buffer.
- Full with a simultaneous pop: the push and the pop both happen, and count is unchanged.
- Empty: `out_valid` = 0, and `out_com`/`out_pc` are don't-care. The bench must not check them.
- Reset values:
  - pc = RESET_PC, count = 0, fetch_cnt = 0.
  - `out_valid` = 0 and `imem_addr` = RESET_PC.
  - `out_com`/`out_pc` = 0.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous).
- The buffer is a circular FIFO with rd/wr pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.

## Timing
- `imem_addr` comes straight from the PC register and has no combinational input path.
- The only combinational paths are `out_valid` (through `redir_valid`) and `push` (through `out_ready`).
- Fetch-to-decode latency is 1 cycle: a word fetched in cycle N is at the head with `out_valid` = 1 in cycle N+1, if the buffer was empty.
- After reset release, the first instruction is valid in the second rising edge's cycle, i.e. one cycle after the first fetch.
- Sustained throughput is 1 instruction per cycle while `out_ready` = 1 and `halt` = 0.
- Redirect asserted in cycle N:
  - `imem_addr` = redir_pc in cycle N+1.
  - That instruction is valid at the output in cycle N+2.
- Halt asserted in cycle N: no push in cycle N.

## Structure
- Shared package `proc_pkg`: `PC_W` = 16, `COM_W` = 16, and the default `RESET_PC`. The decode and execute stages use the same constants for the redirect address.
- One sub-module, `fetch_fifo`: a parameterized circular buffer (push, pop, flush, din/dout, count).
- `ifetch` itself holds the PC register, the push/pop/redirect control, and `fetch_cnt`.

## Test plan
The memory model returns `imem_com = imem_addr ^ 16'hA5A5` in every scenario.
- Reset release with `out_ready` = 1 -> {pc, com} = {0, A5A5}, {1, A5A4}, {2, A5A7} on consecutive cycles, and fetch_cnt = 3 after the third push.
- `out_ready` = 0 for 5 cycles -> `imem_addr` stalls at 2 with 2 entries held. Raising ready delivers pc 0, 1, 2 in order with no gaps.
- Redirect to 16'h0005 while 2 entries are buffered and `out_ready` = 1 -> `out_valid` = 0 in the redirect cycle, the old entries are never delivered, and the next delivered is {5, A5A0}.
- PC at 16'hFFFE with continuous ready -> outputs pc FFFE, FFFF, 0000, and fetch_cnt increments each cycle.
- `halt` = 1 for 4 cycles with the buffer full -> the 2 buffered entries drain, then `out_valid` = 0, and `imem_addr` stays constant. Releasing halt resumes from that address.
- `rst_n` pulsed low mid-stream with the buffer full -> `out_valid` drops immediately, `imem_addr` = RESET_PC, and fetch_cnt = 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Constants and payload types shared by the fetch, decode and execute stages.
package proc_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned COM_W  = 16;
    localparam int unsigned FCNT_W = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [COM_W-1:0] com;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory, decode-handshake and redirect signals of the fetch unit.
interface ifetch_if;
    import proc_pkg::*;

    logic [PC_W-1:0]   imem_addr;
    logic [COM_W-1:0]  imem_com;
    logic              out_valid;
    logic              out_ready;
    logic [COM_W-1:0]  out_com;
    logic [PC_W-1:0]   out_pc;
    logic              redir_valid;
    logic [PC_W-1:0]   redir_pc;
    logic              halt;
    logic [FCNT_W-1:0] fetch_cnt;

    modport master (
        output imem_addr, out_valid, out_com, out_pc, fetch_cnt,
        input  imem_com, out_ready, redir_valid, redir_pc, halt
    );

    modport slave (
        input  imem_addr, out_valid, out_com, out_pc, fetch_cnt,
        output imem_com, out_ready, redir_valid, redir_pc, halt
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer; flush wins over push/pop and empties it in one cycle.
module fetch_fifo
    import proc_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     dout,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push && !flush) mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, prefetch control and fetch counter in front of decode.
module ifetch
    import proc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    ifetch_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [FCNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]  count;
    logic              push, pop, head_valid;
    fetch_entry_t      wr_entry, head;

    // A redirect hides the head so nothing stale can be handed to decode.
    assign head_valid    = (count != '0);
    assign bus.out_valid = head_valid && !bus.redir_valid;
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = !bus.redir_valid && !bus.halt &&
                           ((count < CNT_W'(DEPTH)) || pop);

    assign wr_entry = '{pc: pc_q, com: bus.imem_com};

    always_comb begin
        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (bus.redir_valid) begin
            pc_d = bus.redir_pc;
        end else if (push) begin
            pc_d        = pc_q + PC_W'(1);
            fetch_cnt_d = fetch_cnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redir_valid),
        .din   (wr_entry),
        .dout  (head),
        .count (count)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_com   = head.com;
    assign bus.out_pc    = head.pc;
    assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: hand-derived vector table, random traffic against a queue model, async reset check.
module tb_ifetch;
    import proc_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [15:0] MAGIC = 16'hA5A5;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [15:0] rpc;
        bit          hlt;
        bit          ev;
        logic [15:0] epc;
        logic [15:0] eaddr;
        logic [15:0] ecnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifetch_if bus();
    assign bus.imem_com = bus.imem_addr ^ MAGIC;

    ifetch #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of {pc, com} words plus the fetch PC and counter.
    logic [15:0] m_pc;
    logic [15:0] m_cnt;
    logic [31:0] m_q[$];

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc  = 16'h0000;
        m_cnt = 16'h0000;
        m_q.delete();
    endfunction

    function automatic void model_step(input bit rdy, input bit rv, input logic [15:0] rpc, input bit hlt);
        bit pop_now, push_now;
        if (rv) begin
            m_q.delete();
            m_pc = rpc;
        end else begin
            pop_now  = (m_q.size() > 0) && rdy;
            push_now = !hlt && ((m_q.size() < int'(DEPTH)) || pop_now);
            if (pop_now) void'(m_q.pop_front());
            if (push_now) begin
                m_q.push_back({m_pc, m_pc ^ MAGIC});
                m_pc  = m_pc + 16'd1;
                m_cnt = m_cnt + 16'd1;
            end
        end
    endfunction

    function automatic vec_t mk(input bit rst, input bit rdy, input bit rv, input logic [15:0] rpc,
                                input bit hlt, input bit ev, input logic [15:0] epc,
                                input logic [15:0] eaddr, input logic [15:0] ecnt);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt;
        return v;
    endfunction

    // One clock cycle: drive at the falling edge, check just after, model the next rising edge.
    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        bit mv;
        @(negedge clk);
        if (v.rst) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            model_reset();
        end
        bus.out_ready   = v.rdy;
        bus.redir_valid = v.rv;
        bus.redir_pc    = v.rpc;
        bus.halt        = v.hlt;
        #1;
        if (use_tbl) begin
            chk({tag, "_addr"},  bus.imem_addr, v.eaddr);
            chk({tag, "_valid"}, 16'(bus.out_valid), 16'(v.ev));
            chk({tag, "_cnt"},   bus.fetch_cnt, v.ecnt);
            if (v.ev) begin
                chk({tag, "_pc"},  bus.out_pc,  v.epc);
                chk({tag, "_com"}, bus.out_com, v.epc ^ MAGIC);
            end
        end else begin
            mv = (m_q.size() > 0) && !v.rv;
            chk({tag, "_addr"},  bus.imem_addr, m_pc);
            chk({tag, "_valid"}, 16'(bus.out_valid), 16'(mv));
            chk({tag, "_cnt"},   bus.fetch_cnt, m_cnt);
            if (mv) begin
                chk({tag, "_pc"},  bus.out_pc,  m_q[0][31:16]);
                chk({tag, "_com"}, bus.out_com, m_q[0][15:0]);
            end
        end
        model_step(v.rdy, v.rv, v.rpc, v.hlt);
    endtask

    initial begin
        vec_t v;

        // Reset release, ready high: pc 0,1,2 in consecutive cycles.
        tbl.push_back(mk(1,1,0,16'h0,0, 0,16'h0,16'h0,16'd0));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h0,16'h1,16'd1));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h1,16'h2,16'd2));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h2,16'h3,16'd3));
        // Ready low for 5 cycles stalls fetch at address 2 with 2 entries held.
        tbl.push_back(mk(1,0,0,16'h0,0, 0,16'h0,16'h0,16'd0));
        tbl.push_back(mk(0,0,0,16'h0,0, 1,16'h0,16'h1,16'd1));
        tbl.push_back(mk(0,0,0,16'h0,0, 1,16'h0,16'h2,16'd2));
        tbl.push_back(mk(0,0,0,16'h0,0, 1,16'h0,16'h2,16'd2));
        tbl.push_back(mk(0,0,0,16'h0,0, 1,16'h0,16'h2,16'd2));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h0,16'h2,16'd2));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h1,16'h3,16'd3));
        // Redirect to 5 with two entries buffered.
        tbl.push_back(mk(0,1,1,16'h5,0, 0,16'h0,16'h4,16'd4));
        tbl.push_back(mk(0,1,0,16'h0,0, 0,16'h0,16'h5,16'd4));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h5,16'h6,16'd5));
        // Redirect to FFFE then wrap through 0000.
        tbl.push_back(mk(0,1,1,16'hFFFE,0, 0,16'h0,16'h7,16'd6));
        tbl.push_back(mk(0,1,0,16'h0,0, 0,16'h0,16'hFFFE,16'd6));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'hFFFE,16'hFFFF,16'd7));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'hFFFF,16'h0000,16'd8));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h0000,16'h0001,16'd9));
        // Fill, then halt 4 cycles: drain 2 entries, address frozen, then resume.
        tbl.push_back(mk(0,0,0,16'h0,0, 1,16'h1,16'h2,16'd10));
        tbl.push_back(mk(0,0,0,16'h0,0, 1,16'h1,16'h3,16'd11));
        tbl.push_back(mk(0,1,0,16'h0,1, 1,16'h1,16'h3,16'd11));
        tbl.push_back(mk(0,1,0,16'h0,1, 1,16'h2,16'h3,16'd11));
        tbl.push_back(mk(0,1,0,16'h0,1, 0,16'h0,16'h3,16'd11));
        tbl.push_back(mk(0,1,0,16'h0,1, 0,16'h0,16'h3,16'd11));
        tbl.push_back(mk(0,1,0,16'h0,0, 0,16'h0,16'h3,16'd11));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h3,16'h4,16'd12));
        // Redirect while halted still loads pc and flushes.
        tbl.push_back(mk(0,1,1,16'h0100,1, 0,16'h0,16'h5,16'd13));
        tbl.push_back(mk(0,1,0,16'h0,1, 0,16'h0,16'h0100,16'd13));
        tbl.push_back(mk(0,1,0,16'h0,0, 0,16'h0,16'h0100,16'd13));
        tbl.push_back(mk(0,1,0,16'h0,0, 1,16'h0100,16'h0101,16'd14));

        rst_n           = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 16'h0;
        bus.halt        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr",  bus.imem_addr, 16'h0000);
        chk("reset_valid", 16'(bus.out_valid), 16'h0);
        chk("reset_cnt",   bus.fetch_cnt, 16'h0);
        chk("reset_pc",    bus.out_pc,  16'h0);
        chk("reset_com",   bus.out_com, 16'h0);

        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        for (int i = 0; i < 400; i++) begin
            v = mk(1'b0,
                   $urandom_range(0, 9) < 7,
                   $urandom_range(0, 19) == 0,
                   ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom),
                   $urandom_range(0, 9) < 2,
                   1'b0, 16'h0, 16'h0, 16'h0);
            step(v, 1'b0, "rnd");
        end

        // Fill the buffer, then assert reset between edges and check it takes effect at once.
        v = mk(0,0,0,16'h0,0, 0,16'h0,16'h0,16'h0);
        step(v, 1'b0, "fill");
        step(v, 1'b0, "fill");
        @(negedge clk);
        #2;
        chk("prerst_valid", 16'(bus.out_valid), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 16'(bus.out_valid), 16'h0);
        chk("midrst_addr",  bus.imem_addr, 16'h0000);
        chk("midrst_cnt",   bus.fetch_cnt, 16'h0);
        chk("midrst_pc",    bus.out_pc,  16'h0);
        chk("midrst_com",   bus.out_com, 16'h0);
        model_reset();
        v = mk(1,1,0,16'h0,0, 0,16'h0,16'h0,16'h0);
        step(v, 1'b0, "postrst");
        v.rst = 1'b0;
        repeat (4) step(v, 1'b0, "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
